// File: rtl/alu_iter_pkg.sv
// Shared types, funct3 encodings and FSM states for the iterative ALU.
// ALU_ITER_MUL_EN adds the MULT state used by the optional multiplier.
package alu_iter_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic {
        ADDER_ADD = 1'b0,
        ADDER_SUB = 1'b1
    } adder_op_t;

    localparam logic [2:0] FUNC_ADDSUB = 3'b000;
    localparam logic [2:0] FUNC_SLL    = 3'b001;
    localparam logic [2:0] FUNC_SLT    = 3'b010;
    localparam logic [2:0] FUNC_SLTU   = 3'b011;
    localparam logic [2:0] FUNC_XOR    = 3'b100;
    localparam logic [2:0] FUNC_SR     = 3'b101;
    localparam logic [2:0] FUNC_OR     = 3'b110;
    localparam logic [2:0] FUNC_AND    = 3'b111;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFin
`ifdef ALU_ITER_MUL_EN
        , StMult
`endif
    } alu_state_e;

    function automatic logic is_pure_shift(logic [2:0] f3, logic shadd, logic branch);
        return !shadd && !branch && (f3 == FUNC_SLL || f3 == FUNC_SR);
    endfunction

endpackage

// File: rtl/alu_iter_shift_step.sv
// Combinational shifter moving a word by 0..SHIFT_STEP positions,
// left with zero fill or right with zero/sign fill.
module alu_iter_shift_step #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SHIFT_STEP = 1,
    localparam int unsigned AW        = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] val,
    input  logic [AW-1:0]    amt,
    input  logic             left,
    input  logic             arith,
    output logic [WIDTH-1:0] res
);

    // Only amounts up to SHIFT_STEP are decoded, keeping the mux narrow.
    always_comb begin
        res = val;
        for (int unsigned i = 1; i <= SHIFT_STEP; i++) begin
            if (amt == AW'(i)) begin
                if (left) begin
                    res = val << i;
                end else if (arith) begin
                    res = $signed(val) >>> i;
                end else begin
                    res = val >> i;
                end
            end
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Iterative integer ALU with start/busy/done handshake and multi-cycle shifts.
// Define ALU_ITER_MUL_EN to add the mul port and shift-add multiplier.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SHIFT_STEP = 1,
    localparam int unsigned WSHAM     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [2:0]       f3,
    input  logic             arith_bit,
    input  logic             shadd,
    input  logic             branch,
`ifdef ALU_ITER_MUL_EN
    input  logic             mul,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    alu_state_e       state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       f3_q;
    logic             arith_q, shadd_q, branch_q;
    logic [WSHAM-1:0] rem_q;

    logic [WSHAM-1:0] eff_shamt, rem_next;
    logic [WSHAM:0]   step;
    logic [WIDTH-1:0] shift_res;

    always_comb begin
        eff_shamt = '0;
        if (shadd) begin
            eff_shamt = WSHAM'(f3[2:1]);
        end else if (is_pure_shift(f3, shadd, branch)) begin
            eff_shamt = src_b[WSHAM-1:0];
        end
    end

    assign step = ({1'b0, rem_q} < (WSHAM + 1)'(SHIFT_STEP)) ? {1'b0, rem_q}
                                                             : (WSHAM + 1)'(SHIFT_STEP);
    assign rem_next = rem_q - step[WSHAM-1:0];

    alu_iter_shift_step #(
        .WIDTH      (WIDTH),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift_step (
        .val   (a_q),
        .amt   (step),
        .left  (!(is_pure_shift(f3_q, shadd_q, branch_q) && f3_q == FUNC_SR)),
        .arith (arith_q),
        .res   (shift_res)
    );

    // Results are formed either at accept (live inputs) or on the last shift cycle.
    logic             idle;
    logic [WIDTH-1:0] res_a, res_b;
    logic [2:0]       res_f3;
    logic             res_arith, res_shadd, res_branch;

    assign idle       = (state_q == StIdle);
    assign res_a      = idle ? src_a     : shift_res;
    assign res_b      = idle ? src_b     : b_q;
    assign res_f3     = idle ? f3        : f3_q;
    assign res_arith  = idle ? arith_bit : arith_q;
    assign res_shadd  = idle ? shadd     : shadd_q;
    assign res_branch = idle ? branch    : branch_q;

    adder_op_t        add_op;
    logic [WIDTH-1:0] add_x, add_y;
    logic [WIDTH:0]   sum;
    logic             eq, lt, ltu;

    always_comb begin
        add_x  = res_a;
        add_y  = res_b;
        add_op = ADDER_ADD;
        if (!res_shadd && (res_branch || res_f3 == FUNC_SLT || res_f3 == FUNC_SLTU ||
                           (res_f3 == FUNC_ADDSUB && res_arith))) begin
            add_op = ADDER_SUB;
        end
`ifdef ALU_ITER_MUL_EN
        // The result register doubles as the multiply accumulator.
        if (state_q == StMult) begin
            add_x  = out;
            add_y  = b_q[0] ? a_q : '0;
            add_op = ADDER_ADD;
        end
`endif
    end

    assign sum = {1'b0, add_x} + {1'b0, (add_op == ADDER_SUB) ? ~add_y : add_y}
               + {{WIDTH{1'b0}}, add_op == ADDER_SUB};
    assign eq  = (add_x == add_y);
    assign ltu = !sum[WIDTH];
    assign lt  = (add_x[WIDTH-1] != add_y[WIDTH-1]) ? add_x[WIDTH-1] : sum[WIDTH-1];

    logic [WIDTH-1:0] result;

    always_comb begin
        result = '0;
        if (res_branch) begin
            case (res_f3)
                BR_EQ:   result = WIDTH'(eq);
                BR_NE:   result = WIDTH'(!eq);
                BR_LT:   result = WIDTH'(lt);
                BR_GE:   result = WIDTH'(!lt);
                BR_LTU:  result = WIDTH'(ltu);
                BR_GEU:  result = WIDTH'(!ltu);
                default: result = '0;
            endcase
        end else if (res_shadd) begin
            result = sum[WIDTH-1:0];
        end else begin
            case (res_f3)
                FUNC_ADDSUB:      result = sum[WIDTH-1:0];
                FUNC_SLL, FUNC_SR: result = res_a;
                FUNC_SLT:         result = WIDTH'(lt);
                FUNC_SLTU:        result = WIDTH'(ltu);
                FUNC_XOR:         result = res_a ^ res_b;
                FUNC_OR:          result = res_a | res_b;
                default:          result = res_a & res_b;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            f3_q     <= '0;
            arith_q  <= 1'b0;
            shadd_q  <= 1'b0;
            branch_q <= 1'b0;
            rem_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out      <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q      <= src_a;
                        b_q      <= src_b;
                        f3_q     <= f3;
                        arith_q  <= arith_bit;
                        shadd_q  <= shadd;
                        branch_q <= branch;
`ifdef ALU_ITER_MUL_EN
                        if (mul) begin
                            out     <= '0;
                            rem_q   <= WSHAM'(WIDTH - 1);
                            busy    <= 1'b1;
                            state_q <= StMult;
                        end else
`endif
                        if (eff_shamt == '0) begin
                            out     <= result;
                            done    <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            rem_q   <= eff_shamt;
                            busy    <= 1'b1;
                            state_q <= StShift;
                        end
                    end
                end
                StShift: begin
                    a_q   <= shift_res;
                    rem_q <= rem_next;
                    if (rem_next == '0) begin
                        out     <= result;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StFin;
                    end
                end
`ifdef ALU_ITER_MUL_EN
                StMult: begin
                    out   <= sum[WIDTH-1:0];
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == '0) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StFin;
                    end
                end
`endif
                StFin:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Second-generation iterative integer ALU for the suro-v core.
- Executes add/sub, slt/sltu, and/or/xor, sll/srl/sra, shift-add (shNadd) and branch compares. Only one operation is in flight at a time.
- Shifts are performed over multiple cycles, SHIFT_STEP bit positions per cycle, under an explicit FSM with a start/busy/done handshake and registered result.
- Sits in the execute stage; the core sequencer drives start and waits for done.

Parameters:
- WIDTH, 32, datapath width in bits; power of two, >= 8.
- SHIFT_STEP, 1, maximum bit positions shifted per cycle; power of two, 1..WIDTH.
- WSHAM, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- src_a  in  WIDTH  operand A; the value that is shifted.
- src_b  in  WIDTH  operand B; low WSHAM bits give the shift amount for pure shifts.
- f3  in  3  funct3 code (FUNC_* / BR_* encodings).
- arith_bit  in  1  selects sub (for FUNC_ADDSUB) or sra (for FUNC_SR).
- shadd  in  1  shNadd op; shift amount = f3[2:1].
- branch  in  1  branch compare op.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse; out is valid on this cycle.
- out  out  WIDTH  result; holds its value until the next accepted start.

Behaviour:
- Reset values: out=0, done=0, busy=0, FSM=IDLE, all internal registers 0.
- FSM states:
  - IDLE -> on start: latch operands and control. If eff_shamt==0, compute the result and go to FIN. Otherwise load rem=eff_shamt and go to SHIFT.
  - SHIFT: each cycle, shift the working value by step=min(rem, SHIFT_STEP) and set rem -= step. When rem reaches 0, compute the final result from the shifted value and go to FIN.
  - FIN: done=1 and busy=0 for one cycle, then IDLE.
- eff_shamt:
  - shadd: f3[2:1].
  - pure shift (f3 = FUNC_SLL or FUNC_SR, non-branch, non-shadd): src_b[WSHAM-1:0].
  - all other ops: 0.
- Latency, start to done: 1 + ceil(eff_shamt / SHIFT_STEP) cycles. Ops with eff_shamt=0 take 1 cycle.
- Right shifts fill with 0, or with the sign bit when arith_bit=1. Left shifts fill with 0.
- Final result:
  - pure shift: the shifted value.
  - shadd: shifted + src_b, mod 2^WIDTH.
  - add/sub: mod 2^WIDTH.
  - slt/sltu: {0..., lt}.
  - and/or/xor: bitwise on the latched operands.
  - branch (EQ/NE/LT/GE/LTU/GEU): out = {0..., taken}.
  - Reserved branch f3 codes (2,3): out=0.
- Handshake: start while busy=1, or in FIN, is ignored with no side effect. start in the cycle after FIN (IDLE) is accepted, giving back-to-back ops.
- Operands and control are sampled only at accept. Input changes afterwards have no effect.
- Reset mid-operation (SHIFT or FIN): returns immediately to the reset state. No done pulse is issued for the aborted op.

Optional Feature:
- Macro ALU_ITER_MUL_EN.
- When defined:
  - Adds input port mul (1 bit), sampled at accept; when set, the op is MUL (low WIDTH bits of src_a*src_b) and overrides f3/shadd/branch.
  - Adds FSM state MULT: WIDTH cycles of shift-add, one multiplier bit per cycle, accumulator reused from the adder path.
  - MUL latency = WIDTH + 1 cycles, with done pulse and handshake as above.
- When undefined: no mul port, no MULT state, and no added area.

Decomposition:
- Shared package:
  - word_t, adderOp_t
  - FUNC_* and BR_* encodings
  - ADDER_* op codes
  - alu_iter state enum
- Adder is the existing shared adder module.
- One natural sub-module: alu_iter_shift_step. It is combinational, shifting by 0..SHIFT_STEP with direction and arithmetic fill, and is instantiated once.

Test Plan:
- WIDTH=32, SHIFT_STEP=1: sll src_a=0x1, src_b=5 -> done at cycle 6 after start, out=0x20; busy high cycles 1-5.
- SHIFT_STEP=4: sra src_a=0x80000000, src_b=31 -> done at cycle 9, out=0xFFFFFFFF. Same op with srl -> out=0x00000001.
- sh3add (shadd=1, f3=3'b110) src_a=0x10, src_b=0x3 -> out=0x83, latency 1+ceil(3/SHIFT_STEP). Branch BLT src_a=-1, src_b=0 -> out=1 in 1 cycle; BLTU with the same operands -> out=0.
- A second start pulsed every cycle during a shift by 7 is ignored; start in the cycle after done is accepted with no gap. Operand inputs changed mid-op do not change the result.
- rst_n low during SHIFT with rem=3 -> out=0, busy=0, done never pulses. After release, add 2+3 -> out=5 in 1 cycle.
- ALU_ITER_MUL_EN defined, WIDTH=32: mul 0xFFFF x 0x10001 -> out=0xFFFFFFFF at cycle 33. Macro undefined: the build has no mul port and the regression runs unchanged.
